// File: rtl/sram_responder.sv
// sram_responder: dual-bank synchronous memory responder for the calculator
// datapath. Bank A holds word bits 63:32, bank B holds bits 31:0.
//
// Behaviour:
//   - one-cycle registered read latency with a single-cycle r_valid pulse
//   - write-first forwarding when a read and a write hit the same address
//   - sticky addr_err for any strobe whose address is >= DEPTH
//   - optional post-reset clear sequencer, compiled only when MEM_CLEAR_EN
//     is defined; without it memory contents survive reset untouched
//
// Handshake: read/write are active-low strobes, sampled on every rising
// edge while ready=1. There is no backpressure; ready=0 means strobes are
// dropped silently (no storage change, no r_valid, no addr_err). An accepted
// read returns its data and r_valid=1 in the cycle after the sampling edge.
//
// dbg_state exposes the FSM state for checkers and bring-up.

package calculator_pkg;
  localparam int ADDR_W = 4;
endpackage

module sram_responder #(
  parameter int ADDR_W = calculator_pkg::ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              read,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              write,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data_a,
  input  logic [31:0]       w_data_b,
  output logic [31:0]       r_data_a,
  output logic [31:0]       r_data_b,
  output logic              r_valid,
  output logic              ready,
  output logic              addr_err,
  output logic [1:0]        dbg_state
);

  // Narrowest index that covers DEPTH entries; range checks use the full
  // address, so dropping upper bits here is safe.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  localparam logic [1:0] S_RST   = 2'd0;
`ifdef MEM_CLEAR_EN
  localparam logic [1:0] S_CLEAR = 2'd1;
`endif
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]  state;
  logic [31:0] bank_a [DEPTH];
  logic [31:0] bank_b [DEPTH];

  logic             rd_req, wr_req;
  logic             rd_in_range, wr_in_range;
  logic             rd_ok, wr_ok, fwd;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  assign ready     = (state == S_READY);
  assign dbg_state = state;

  assign rd_req      = ready & ~read;
  assign wr_req      = ready & ~write;
  assign rd_in_range = ({1'b0, r_addr} < DEPTH_W);
  assign wr_in_range = ({1'b0, w_addr} < DEPTH_W);
  assign rd_ok       = rd_req & rd_in_range;
  assign wr_ok       = wr_req & wr_in_range;
  assign fwd         = wr_ok & (w_addr == r_addr);
  assign rd_idx      = r_addr[IDX_W-1:0];
  assign wr_idx      = w_addr[IDX_W-1:0];

`ifdef MEM_CLEAR_EN
  // One extra bit so the counter reaches DEPTH-1 without wrapping even when
  // DEPTH fills the whole address space.
  localparam logic [ADDR_W:0] CLR_LAST = DEPTH_W - 1'b1;

  logic [ADDR_W:0]  clr_cnt;
  logic             clr_we;
  logic [IDX_W-1:0] clr_idx;

  assign clr_we  = (state == S_CLEAR);
  assign clr_idx = clr_cnt[IDX_W-1:0];

  // Clear counter: walks 0..DEPTH-1 while clearing, restarts from 0 on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    else             clr_cnt <= '0;
  end

  // Storage write port: zero-fill during clear, otherwise accepted writes.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      bank_a[clr_idx] <= '0;
      bank_b[clr_idx] <= '0;
    end else if (wr_ok) begin
      bank_a[wr_idx] <= w_data_a;
      bank_b[wr_idx] <= w_data_b;
    end
  end
`else
  // Storage write port: accepted writes only; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      bank_a[wr_idx] <= w_data_a;
      bank_b[wr_idx] <= w_data_b;
    end
  end
`endif

  // Control FSM: leave reset on the first edge, optionally via the clear pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_RST;
    end else begin
      case (state)
`ifdef MEM_CLEAR_EN
        S_RST:   state <= S_CLEAR;
        S_CLEAR: if (clr_cnt == CLR_LAST) state <= S_READY;
`else
        S_RST:   state <= S_READY;
`endif
        S_READY: state <= S_READY;
        default: state <= S_RST;
      endcase
    end
  end

  // Read port: registered data with write-first forwarding; data holds when
  // no read is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid  <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      r_valid <= rd_ok;
      if (rd_ok) begin
        r_data_a <= fwd ? w_data_a : bank_a[rd_idx];
        r_data_b <= fwd ? w_data_b : bank_b[rd_idx];
      end
    end
  end

  // Sticky address error: any out-of-range strobe while ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_err <= 1'b0;
    end else if ((rd_req && !rd_in_range) || (wr_req && !wr_in_range)) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder (ADDR_W=4, DEPTH=12). Honours MEM_CLEAR_EN
// the same way the design does. Reference model: plain arrays per bank with
// a per-address "known" flag, so uninitialised contents are never compared.

module tb_sram_responder;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
`ifdef MEM_CLEAR_EN
  localparam bit CLEAR_ON  = 1'b1;
  localparam int READY_LAT = DEPTH + 1;
`else
  localparam bit CLEAR_ON  = 1'b0;
  localparam int READY_LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              read, write;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [31:0]       w_data_a, w_data_b;
  logic [31:0]       r_data_a, r_data_b;
  logic              r_valid, ready, addr_err;
  logic [1:0]        dbg_state;

  always #5 clk_i = ~clk_i;

  sram_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .read     (read),
    .r_addr   (r_addr),
    .write    (write),
    .w_addr   (w_addr),
    .w_data_a (w_data_a),
    .w_data_b (w_data_b),
    .r_data_a (r_data_a),
    .r_data_b (r_data_b),
    .r_valid  (r_valid),
    .ready    (ready),
    .addr_err (addr_err),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] m_a [16];
  logic [31:0] m_b [16];
  bit          m_known [16];
  logic [63:0] m_last;
  bit          m_last_known;
  bit          m_err;
  logic [63:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    m_err        = 1'b0;
    m_last       = '0;
    m_last_known = 1'b1;
    exp_q.delete();
    if (CLEAR_ON) begin
      for (int i = 0; i < 16; i++) begin
        m_a[i] = '0; m_b[i] = '0; m_known[i] = (i < DEPTH);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {r_data_a, r_data_b}, 64'h0);
    check({tag, "_valid"}, 64'(r_valid),  64'h0);
    check({tag, "_ready"}, 64'(ready),    64'h0);
    check({tag, "_err"},   64'(addr_err), 64'h0);
  endtask

  // ---------------- driver ----------------
  // One accepted-mode cycle: drive strobes, predict, clock, compare.
  task automatic do_cycle(input bit rd_n, input logic [3:0] ra, input bit wr_n,
                          input logic [3:0] wa, input logic [31:0] da, input logic [31:0] db);
    bit rd_ok, wr_ok;
    logic [63:0] expd;
    read = rd_n; r_addr = ra; write = wr_n; w_addr = wa;
    w_data_a = da; w_data_b = db;
    rd_ok = !rd_n && (int'(ra) < DEPTH);
    wr_ok = !wr_n && (int'(wa) < DEPTH);
    if ((!rd_n && int'(ra) >= DEPTH) || (!wr_n && int'(wa) >= DEPTH)) m_err = 1'b1;
    if (rd_ok) begin
      if (wr_ok && wa == ra) begin
        m_last = {da, db}; m_last_known = 1'b1;
      end else begin
        m_last = {m_a[ra], m_b[ra]}; m_last_known = m_known[ra];
      end
    end
    if (wr_ok) begin
      m_a[wa] = da; m_b[wa] = db; m_known[wa] = 1'b1;
    end
    if (m_last_known) exp_q.push_back(m_last);
    step();
    read = 1'b1; write = 1'b1;
    check("r_valid", 64'(r_valid), 64'(rd_ok));
    check("addr_err", 64'(addr_err), 64'(m_err));
    if (exp_q.size() > 0) begin
      expd = exp_q.pop_front();
      check("r_data", {r_data_a, r_data_b}, expd);
    end
  endtask

  task automatic idle();
    do_cycle(1'b1, 4'd0, 1'b1, 4'd0, 32'h0, 32'h0);
  endtask

  // Counts edges from reset release until ready while hammering strobes that
  // must be ignored (out-of-range read, write to address 2).
  task automatic wait_ready();
    int cnt = 0;
    read = 1'b0; r_addr = 4'd13; write = 1'b0; w_addr = 4'd2;
    w_data_a = 32'hFFFF_FFFF; w_data_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      step();
      cnt++;
      if (ready) break;
    end
    read = 1'b1; write = 1'b1;
    check("ready_lat", 64'(cnt), 64'(READY_LAT));
    check("ready_up", 64'(ready), 64'h1);
    check("nr_valid", 64'(r_valid), 64'h0);
    check("nr_err", 64'(addr_err), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0; read = 1'b1; write = 1'b1;
    r_addr = '0; w_addr = '0; w_data_a = '0; w_data_b = '0;
    for (int i = 0; i < 16; i++) begin
      m_a[i] = '0; m_b[i] = '0; m_known[i] = 1'b0;
    end
    repeat (3) step();
    check_reset_outputs("rst");

    rst_ni = 1'b1;
    model_reset();
    wait_ready();

    // Sweep every in-range address (all zero after a clear).
    for (int a = 0; a < DEPTH; a++) do_cycle(1'b0, 4'(a), 1'b1, 4'd0, 32'h0, 32'h0);
    idle();

    // Single read pulse, then idle shows r_valid dropping.
    do_cycle(1'b0, 4'd5, 1'b1, 4'd0, 32'h0, 32'h0);
    idle();

    // Write then read back.
    do_cycle(1'b1, 4'd0, 1'b0, 4'd3, 32'hDEADBEEF, 32'h12345678);
    do_cycle(1'b0, 4'd3, 1'b1, 4'd0, 32'h0, 32'h0);
    check("rd3_a", 64'(r_data_a), 64'hDEADBEEF);
    check("rd3_b", 64'(r_data_b), 64'h12345678);
    idle();

    // Forwarding on same address; independence on different addresses.
    do_cycle(1'b1, 4'd0, 1'b0, 4'd9, 32'hA5A5A5A5, 32'h5A5A5A5A);
    do_cycle(1'b0, 4'd7, 1'b0, 4'd7, 32'h1, 32'h2);
    check("fwd7", {r_data_a, r_data_b}, {32'h1, 32'h2});
    do_cycle(1'b0, 4'd9, 1'b0, 4'd8, 32'h11111111, 32'h22222222);
    check("old9", {r_data_a, r_data_b}, {32'hA5A5A5A5, 32'h5A5A5A5A});
    do_cycle(1'b0, 4'd8, 1'b1, 4'd0, 32'h0, 32'h0);

    // Out-of-range read and write: sticky error, no r_valid, data held.
    do_cycle(1'b0, 4'd13, 1'b1, 4'd0, 32'h0, 32'h0);
    check("oor_err", 64'(addr_err), 64'h1);
    do_cycle(1'b1, 4'd0, 1'b0, 4'd14, 32'hCAFE0000, 32'h0000CAFE);
    idle();
    do_cycle(1'b0, 4'd3, 1'b1, 4'd0, 32'h0, 32'h0);
    check("post_err_err", 64'(addr_err), 64'h1);

    // Randomised traffic including out-of-range and same-address collisions.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] ra, wa;
      ra = 4'($urandom_range(0, 15));
      wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      do_cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom, $urandom);
    end

    // Reset asserted while a read strobe is pending: no r_valid ever appears.
    do_cycle(1'b1, 4'd0, 1'b0, 4'd3, 32'h0BADF00D, 32'hFEEDFACE);
    read = 1'b0; r_addr = 4'd3;
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("mid_rst");
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_valid", 64'(r_valid), 64'h0);
    end
    read = 1'b1;
    rst_ni = 1'b1;
    model_reset();
    wait_ready();
    do_cycle(1'b0, 4'd3, 1'b1, 4'd0, 32'h0, 32'h0);
    do_cycle(1'b0, 4'd2, 1'b1, 4'd0, 32'h0, 32'h0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
